// File: rtl/rf_spi_pkg.sv
// Shared types and constants for the MRF24J40-class SPI master.
// Latency: n/a (types, constants and a pure frame-builder function).
// Backpressure: n/a.
package rf_spi_pkg;

  typedef enum logic [1:0] {
    SHORT_RD = 2'b00,
    SHORT_WR = 2'b01,
    LONG_RD  = 2'b10,
    LONG_WR  = 2'b11
  } rf_inst_t;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } spi_state_t;

  localparam logic [4:0] SHORT_FRAME_BITS = 5'd16;
  localparam logic [4:0] LONG_FRAME_BITS  = 5'd24;

  // Frames are left-aligned in 24 bits so the bit on the wire is always [23];
  // short frames are zero-padded below, which keeps mosi low once drained.
  function automatic logic [23:0] build_frame(input logic [9:0] addr,
                                              input logic [7:0] data,
                                              input rf_inst_t   cmd);
    logic       rw;
    logic [7:0] byte_v;
    rw     = cmd[0];
    byte_v = rw ? data : 8'h00;
    if (cmd == LONG_RD || cmd == LONG_WR)
      return {1'b1, addr, rw, 4'b0000, byte_v};
    else
      return {1'b0, addr[5:0], rw, byte_v, 8'h00};
  endfunction

endpackage

// File: rtl/rf_spi_sclk_gen.sv
// SCLK generator: CLK_DIV-cycle phase timer with rise/fall strobes for the master FSM.
// Latency: tick asserts in the last cycle of each CLK_DIV phase; sclk toggles on that edge.
// Backpressure: none; counter is held at zero and restarts whenever en is low.
module rf_spi_sclk_gen #(
  parameter int CLK_DIV = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic run,
  output logic sclk,
  output logic tick,
  output logic rise_en,
  output logic fall_en
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick    = en && (cnt == CW'(CLK_DIV - 1));
  assign rise_en = tick && run && !sclk;
  assign fall_en = tick && run && sclk;

  // Phase counter: wraps every CLK_DIV cycles while enabled, parked at 0 otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (!en || tick)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

  // SCLK toggles only while shifting, so it always idles low (mode 0)
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sclk <= 1'b0;
    else if (!run)
      sclk <= 1'b0;
    else if (tick)
      sclk <= ~sclk;
  end

endmodule

// File: rtl/rf_spi_master.sv
// SPI master serialising one short/long register access per cs_in strobe; optional INT sync via RF_SPI_INTR_SYNC_EN.
// Latency: ready low 1 cycle after strobe; back high 1 + CLK_DIV*(2N+3) cycles after it (N = 16 or 24).
// Backpressure: ready=0 while a frame is in flight; cs_in outside IDLE is dropped, never queued.
module rf_spi_master
  import rf_spi_pkg::*;
#(
  parameter int CLK_DIV = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] addr_in,
  input  logic [7:0] data_in,
  input  logic [1:0] inst,
  input  logic       cs_in,
  output logic       ready,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso,
  output logic       cs_n,
  input  logic       rf_int_n,
  output logic       intr_out
);

  spi_state_t state, state_nxt;
  rf_inst_t   cmd;

  logic [23:0] shreg;
  logic [4:0]  bit_cnt;
  logic [7:0]  rx;
  logic        rd_op;

  logic gen_en, gen_run, tick, rise_en, fall_en;
  logic accept;

  assign cmd    = rf_inst_t'(inst);
  assign accept = (state == IDLE) && cs_in;

  rf_spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk     (clk),
    .rst     (rst),
    .en      (gen_en),
    .run     (gen_run),
    .sclk    (sclk),
    .tick    (tick),
    .rise_en (rise_en),
    .fall_en (fall_en)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // FSM next state: every non-idle phase is paced by the shared sclk generator
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cs_in) state_nxt = SETUP;
      SETUP:   if (tick) state_nxt = SHIFT;
      SHIFT:   if (fall_en && bit_cnt == 5'd0) state_nxt = HOLD;
      HOLD:    if (tick) state_nxt = GAP;
      GAP:     if (tick) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: bus pins and generator controls decoded straight from state
  always_comb begin
    ready   = 1'b0;
    cs_n    = 1'b1;
    gen_en  = 1'b1;
    gen_run = 1'b0;
    case (state)
      IDLE: begin
        ready  = 1'b1;
        gen_en = 1'b0;
      end
      SETUP: cs_n = 1'b0;
      SHIFT: begin
        cs_n    = 1'b0;
        gen_run = 1'b1;
      end
      HOLD:    cs_n = 1'b0;
      default: cs_n = 1'b1;
    endcase
    mosi = cs_n ? 1'b0 : shreg[23];
  end

  // Frame datapath: load on accept, sample miso on sclk rise, shift on sclk fall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
      rx      <= '0;
      rd_op   <= 1'b0;
    end else if (accept) begin
      shreg   <= build_frame(addr_in, data_in, cmd);
      bit_cnt <= inst[1] ? LONG_FRAME_BITS : SHORT_FRAME_BITS;
      rd_op   <= ~inst[0];
    end else if (rise_en) begin
      rx      <= {rx[6:0], miso};
      bit_cnt <= bit_cnt - 5'd1;
    end else if (fall_en) begin
      shreg   <= {shreg[22:0], 1'b0};
    end
  end

  // Read result: published on the edge that leaves HOLD, i.e. as cs_n rises
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data  <= 8'h00;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      if (state == HOLD && tick && rd_op) begin
        rd_data  <= rx;
        rd_valid <= 1'b1;
      end
    end
  end

`ifdef RF_SPI_INTR_SYNC_EN
  logic [1:0] int_sync;

  // Two-flop synchroniser for the asynchronous INT pin, preset to the idle level
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      int_sync <= 2'b11;
    else
      int_sync <= {int_sync[0], rf_int_n};
  end

  assign intr_out = ~int_sync[1];
`else
  // INT is trusted to be synchronous already: zero-latency inversion
  assign intr_out = ~rf_int_n;
`endif

endmodule

// File: tb/tb_rf_spi_master.sv
// Directed bench for rf_spi_master with an SPI slave model and immediate-assertion checks.
// Latency: checks ready/frame timing against 1 + CLK_DIV*(2N+3).
// Backpressure: exercises ignored mid-frame strobes and cs_in held high across frames.
module tb_rf_spi_master;

  localparam int K = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] addr_in;
  logic [7:0] data_in;
  logic [1:0] inst;
  logic       cs_in;
  logic       ready;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       sclk;
  logic       mosi;
  logic       miso = 1'b0;
  logic       cs_n;
  logic       rf_int_n;
  logic       intr_out;

  always #5 clk = ~clk;

  rf_spi_master #(.CLK_DIV(K)) dut (
    .clk      (clk),
    .rst      (rst),
    .addr_in  (addr_in),
    .data_in  (data_in),
    .inst     (inst),
    .cs_in    (cs_in),
    .ready    (ready),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .sclk     (sclk),
    .mosi     (mosi),
    .miso     (miso),
    .cs_n     (cs_n),
    .rf_int_n (rf_int_n),
    .intr_out (intr_out)
  );

  int n_vec = 0;
  int n_err = 0;

  // Slave model / bus monitor state
  logic [23:0] miso_pat = 24'h0;
  logic [23:0] mosi_cap = 24'h0;
  logic        sclk_q = 1'b0;
  logic        cs_n_q = 1'b1;
  logic        rdv_aligned = 1'b0;
  int rise_cnt = 0, bit_idx = 0, frame_cnt = 0, low_cnt = 0;
  int high_run = 0, last_gap = 0, rdv_cnt = 0;

  always @(negedge clk) begin
    if (rd_valid) begin
      rdv_cnt++;
      rdv_aligned = cs_n && !cs_n_q;
    end
    if (!cs_n && cs_n_q) begin
      frame_cnt++;
      last_gap = high_run;
      rise_cnt = 0;
      bit_idx  = 0;
      low_cnt  = 0;
      mosi_cap = 24'h0;
    end
    if (cs_n) high_run++;
    else begin
      high_run = 0;
      low_cnt++;
      if (sclk && !sclk_q) begin
        mosi_cap = {mosi_cap[22:0], mosi};
        rise_cnt++;
      end
      if (!sclk && sclk_q && bit_idx < 23) bit_idx++;
    end
    miso   = cs_n ? 1'b0 : miso_pat[5'(23 - bit_idx)];
    sclk_q = sclk;
    cs_n_q = cs_n;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one command from posedge+1; optional second strobe at cycle 'repulse'.
  task automatic issue(input logic [9:0] a, input logic [7:0] d, input logic [1:0] i,
                       input int repulse, output int lat, output logic rdy1, output logic csn1);
    addr_in = a; data_in = d; inst = i; cs_in = 1'b1;
    lat = 0; rdy1 = 1'bx; csn1 = 1'bx;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin
        rdy1  = ready;
        csn1  = cs_n;
        cs_in = 1'b0;
      end
      if (repulse != 0 && lat == repulse) begin
        cs_in = 1'b1; addr_in = 10'h3FF; data_in = 8'hFF; inst = 2'b11;
      end
      if (repulse != 0 && lat == repulse + 1) cs_in = 1'b0;
    end while (!ready && lat < 2000);
  endtask

  initial begin
    int   lat, f0, r0;
    logic rdy1, csn1;

    rst = 1'b1; addr_in = '0; data_in = '0; inst = '0; cs_in = 1'b0; rf_int_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready",    ready,    1);
    check("rst_cs_n",     cs_n,     1);
    check("rst_sclk",     sclk,     0);
    check("rst_mosi",     mosi,     0);
    check("rst_rd_data",  rd_data,  0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_intr",     intr_out, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Short write 0x18 <- 0xA5
    r0 = rdv_cnt;
    issue(10'h018, 8'hA5, 2'b01, 0, lat, rdy1, csn1);
    check("sw_ready_fall", rdy1, 0);
    check("sw_cs_n_fall",  csn1, 0);
    check("sw_latency",    lat, 176);
    check("sw_mosi",       mosi_cap, 24'h0031A5);
    check("sw_rises",      rise_cnt, 16);
    check("sw_cs_low",     low_cnt, 170);
    check("sw_no_rdv",     rdv_cnt - r0, 0);

    // Long read 0x300, slave returns 0x3C
    miso_pat = 24'h00003C;
    r0 = rdv_cnt;
    issue(10'h300, 8'h77, 2'b10, 0, lat, rdy1, csn1);
    check("lr_latency",  lat, 256);
    check("lr_mosi",     mosi_cap, 24'hE00000);
    check("lr_rises",    rise_cnt, 24);
    check("lr_cs_low",   low_cnt, 250);
    check("lr_rdv_once", rdv_cnt - r0, 1);
    check("lr_rdv_csn",  rdv_aligned, 1);
    check("lr_rd_data",  rd_data, 8'h3C);

    // Short read 0x3F, slave returns 0xC3 in the data byte
    miso_pat = 24'h00C300;
    issue(10'h03F, 8'h99, 2'b00, 0, lat, rdy1, csn1);
    check("sr_latency", lat, 176);
    check("sr_mosi",    mosi_cap, 24'h007E00);
    check("sr_rd_data", rd_data, 8'hC3);

    // Second strobe 10 cycles into a frame is ignored
    f0 = frame_cnt;
    issue(10'h005, 8'h5A, 2'b01, 10, lat, rdy1, csn1);
    check("ig_latency", lat, 176);
    check("ig_mosi",    mosi_cap, 24'h000B5A);
    check("ig_frames",  frame_cnt - f0, 1);
    repeat (20) @(posedge clk);
    #1;
    check("ig_no_queue",  frame_cnt - f0, 1);
    check("ig_rd_held",   rd_data, 8'hC3);

    // Reset mid-SHIFT after 7 bits
    addr_in = 10'h018; data_in = 8'hA5; inst = 2'b01; cs_in = 1'b1;
    @(posedge clk); #1;
    cs_in = 1'b0;
    @(negedge clk); #1;
    lat = 0;
    while (rise_cnt < 7 && lat < 2000) begin
      @(posedge clk); #1;
      lat++;
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("ab_cs_n",    cs_n, 1);
    check("ab_sclk",    sclk, 0);
    check("ab_ready",   ready, 1);
    check("ab_rd_data", rd_data, 8'h00);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    issue(10'h018, 8'hA5, 2'b01, 0, lat, rdy1, csn1);
    check("ab_re_latency", lat, 176);
    check("ab_re_mosi",    mosi_cap, 24'h0031A5);
    check("ab_re_rises",   rise_cnt, 16);

    // Back-to-back with cs_in held high
    f0 = frame_cnt;
    addr_in = 10'h001; data_in = 8'h11; inst = 2'b01; cs_in = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (!ready && lat < 2000) begin
      @(posedge clk); #1;
      lat++;
    end
    @(posedge clk); #1;
    check("bb_reaccept", ready, 0);
    cs_in = 1'b0;
    lat = 0;
    while (!ready && lat < 2000) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bb_frames", frame_cnt - f0, 2);
    check("bb_gap_ok", (last_gap >= K), 1);
    check("bb_mosi",   mosi_cap, 24'h000311);

    // Interrupt conditioning
    @(posedge clk); #1;
    rf_int_n = 1'b0;
`ifdef RF_SPI_INTR_SYNC_EN
    #1;
    check("int_not_yet", intr_out, 0);
    lat = 0;
    while (!intr_out && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("int_sync_lat", lat, 2);
`else
    #1;
    check("int_comb", intr_out, 1);
`endif
    rf_int_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("int_release", intr_out, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
